// File: rtl/simpleadder_result_fifo.sv
// Result buffer behind the simple adder: first-word-fall-through FIFO with a
// valid/ready consumer side and a sticky drop flag and counter on the producer side.
module simpleadder_result_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       sig_clock,
  input  logic                       sig_rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // A full FIFO still accepts a result when the head leaves on the same edge.
  assign pop  = !empty && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_ff @(posedge sig_clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge sig_clock or negedge sig_rst) begin
    if (!sig_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Clear takes effect first, so a drop on the clearing edge still registers.
  always_ff @(posedge sig_clock or negedge sig_rst) begin
    if (!sig_rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_simpleadder_result_fifo.sv
// Directed bench for simpleadder_result_fifo: a queue scoreboard holds the
// expected FIFO contents and is checked on every pop and after every edge.
module tb_simpleadder_result_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         sig_clock = 1'b0;
  logic         sig_rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [2:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;
  logic [7:0]   drop_cnt;
  logic         clr_ovf;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  bit           m_ovf;
  int           m_drop;

  simpleadder_result_fifo #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .sig_clock (sig_clock),
    .sig_rst   (sig_rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  always #5 sig_clock = ~sig_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("count",     count,     q.size());
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_data",  out_data,  (q.size() != 0) ? q[0] : 0);
    chk("full",      full,      q.size() == DEPTH);
    chk("empty",     empty,     q.size() == 0);
    chk("overflow",  overflow,  m_ovf);
    chk("drop_cnt",  drop_cnt,  m_drop);
  endtask

  // One clock: drive inputs after the falling edge, update the model, check after the next falling edge.
  task automatic cycle(input bit iv, input logic [W-1:0] id, input bit rdy, input bit clr);
    bit pop;
    bit drop;
    in_valid  = iv;
    in_data   = id;
    out_ready = rdy;
    clr_ovf   = clr;
    pop  = (q.size() != 0) && rdy;
    drop = iv && (q.size() == DEPTH) && !pop;
    if (pop) begin
      chk("pop_data", out_data, q[0]);
      void'(q.pop_front());
    end
    if (iv && !drop) q.push_back(id);
    if (clr) begin
      m_ovf  = drop;
      m_drop = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    @(posedge sig_clock);
    @(negedge sig_clock);
    chk_state();
  endtask

  initial begin
    sig_rst   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    m_ovf     = 1'b0;
    m_drop    = 0;
    repeat (2) @(negedge sig_clock);
    chk_state();
    sig_rst = 1'b1;

    // Three results held, then drained in order
    cycle(1, 8'd3, 0, 0);
    cycle(1, 8'd5, 0, 0);
    cycle(1, 8'd9, 0, 0);
    cycle(0, 8'd0, 0, 0);
    chk("tp1_count", count, 3);
    chk("tp1_head", out_data, 3);
    repeat (3) cycle(0, 8'd0, 1, 0);
    chk("tp1_empty", empty, 1);
    chk("tp1_data0", out_data, 0);

    // Six pushes into a four-deep FIFO
    for (int i = 0; i < 6; i++) cycle(1, W'(10 + i), 0, 0);
    chk("tp2_full", full, 1);
    chk("tp2_count", count, 4);
    chk("tp2_ovf", overflow, 1);
    chk("tp2_drop", drop_cnt, 2);
    chk("tp2_head", out_data, 10);

    // Push and pop together while full
    cycle(1, 8'd7, 1, 0);
    chk("tp3_drop", drop_cnt, 2);
    chk("tp3_count", count, 4);
    repeat (4) cycle(0, 8'd0, 1, 0);
    chk("tp3_empty", empty, 1);

    // Streaming with the consumer always ready
    cycle(0, 8'd0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(1, W'(8'h40 + i), 1, 0);
      chk("tp4_cnt_le1", count <= 1, 1);
    end
    cycle(0, 8'd0, 1, 0);
    chk("tp4_drop", drop_cnt, 0);
    chk("tp4_empty", empty, 1);

    // Drop counter clear-vs-drop priority and saturation
    for (int i = 0; i < 4; i++) cycle(1, W'(8'h80 + i), 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'hEE, 0, 0);
    chk("tp5_drop5", drop_cnt, 5);
    cycle(1, 8'hEE, 0, 1);
    chk("tp5_clr_ovf", overflow, 1);
    chk("tp5_clr_drop", drop_cnt, 1);
    for (int i = 0; i < 300; i++) cycle(1, 8'hDD, 0, 0);
    chk("tp5_sat", drop_cnt, 255);

    // Asynchronous reset with three entries held
    cycle(0, 8'd0, 1, 0);
    chk("tp6_pre_count", count, 3);
    #2;
    sig_rst = 1'b0;
    #1;
    q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    chk("tp6_rst_valid", out_valid, 0);
    chk("tp6_rst_count", count, 0);
    chk("tp6_rst_drop", drop_cnt, 0);
    chk("tp6_rst_ovf", overflow, 0);
    @(negedge sig_clock);
    sig_rst = 1'b1;
    cycle(1, 8'd4, 0, 0);
    chk("tp6_push4", out_data, 4);
    chk("tp6_valid", out_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
